// File: rtl/dll_pkg.sv
// Shared constants, state encoding and saturating code arithmetic for the
// FMDLL delay-code controller.
package dll_pkg;

    localparam int W          = 10;
    localparam int SETTLE     = 3;
    localparam int FILT_LEN   = 4;
    localparam int LOCK_CNT   = 8;

    localparam logic [W-1:0] CODE_MID   = W'(512);
    localparam logic [W-1:0] CODE_MAX   = W'(1023);
    localparam logic [W-1:0] RECOV_STEP = W'(64);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAR     = 3'd1,
        TRACK   = 3'd2,
        RECOVER = 3'd3,
        HOLD    = 3'd4
    } state_t;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] d);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, d};
        return s[W] ? CODE_MAX : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] d);
        return (a < d) ? '0 : a - d;
    endfunction

endpackage

// File: rtl/dll_vote_filter.sv
// Signed PD vote accumulator with post-step settle blanking; emits one-cycle
// step_up/step_dn pulses when the net vote reaches +/-FILT_LEN.
module dll_vote_filter
    import dll_pkg::*;
(
    input  logic clk_ext,
    input  logic rst,
    input  logic clr_i,
    input  logic blank_i,
    input  logic act_i,
    input  logic up_i,
    input  logic dn_i,
    output logic step_up_o,
    output logic step_dn_o
);

    localparam int VW  = $clog2(FILT_LEN) + 2;
    localparam int SCW = $clog2(SETTLE + 1);
    localparam logic signed [VW-1:0] V_UP = VW'(FILT_LEN - 1);
    localparam logic signed [VW-1:0] V_DN = VW'(1 - FILT_LEN);
    localparam logic signed [VW-1:0] ONE  = VW'(1);

    logic signed [VW-1:0] v_q, v_d;
    logic [SCW-1:0]       b_q, b_d;
    logic                 up_only, dn_only;

    assign up_only   = up_i & ~dn_i;
    assign dn_only   = dn_i & ~up_i;
    // The vote that lands the accumulator on the threshold is the step itself
    assign step_up_o = act_i && (b_q == '0) && up_only && (v_q == V_UP);
    assign step_dn_o = act_i && (b_q == '0) && dn_only && (v_q == V_DN);

    always_comb begin
        v_d = v_q;
        b_d = b_q;
        if (blank_i) begin
            v_d = '0;
            b_d = SCW'(SETTLE);
        end else if (clr_i) begin
            v_d = '0;
            b_d = '0;
        end else if (act_i) begin
            if (b_q != '0) begin
                b_d = b_q - SCW'(1);
            end else if (step_up_o || step_dn_o) begin
                v_d = '0;
                b_d = SCW'(SETTLE);
            end else if (up_only) begin
                v_d = v_q + ONE;
            end else if (dn_only) begin
                v_d = v_q - ONE;
            end
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            v_q <= '0;
            b_q <= '0;
        end else begin
            v_q <= v_d;
            b_q <= b_d;
        end
    end

endmodule

// File: rtl/dll_code_ctrl.sv
// FMDLL delay-code controller: SAR coarse acquisition, vote-filtered
// bang-bang tracking with lock detection, and harmonic-lock recovery.
module dll_code_ctrl
    import dll_pkg::*;
(
    input  logic         clk_ext,
    input  logic         rst,
    input  logic         en,
    input  logic         pd_up,
    input  logic         pd_dn,
    input  logic         hld1,
    input  logic         hld2,
    output logic [W-1:0] Q,
    output logic         locked,
    output logic         cal_done,
    output logic [2:0]   state
);

    localparam int BW  = $clog2(W);
    localparam int SCW = $clog2(SETTLE + 1);
    localparam int LW  = $clog2(LOCK_CNT + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
    logic           has_last_q, has_last_d;
    logic           last_up_q, last_up_d;
    logic           locked_q, locked_d;
    logic           cal_q, cal_d;
    logic           blank, clr, step_up, step_dn;

    assign clr = (state_d != TRACK);

    dll_vote_filter u_filt (
        .clk_ext   (clk_ext),
        .rst       (rst),
        .clr_i     (clr),
        .blank_i   (blank),
        .act_i     (state_q == TRACK),
        .up_i      (pd_up),
        .dn_i      (pd_dn),
        .step_up_o (step_up),
        .step_dn_o (step_dn)
    );

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;
        has_last_d = has_last_q;
        last_up_d  = last_up_q;
        locked_d   = locked_q;
        cal_d      = cal_q;
        blank      = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SAR;
                    q_d     = CODE_MID;
                    bit_d   = BW'(W - 1);
                    cnt_d   = '0;
                end
            end
            SAR: begin
                if (cnt_q != SCW'(SETTLE)) begin
                    cnt_d = cnt_q + SCW'(1);
                end else begin
                    cnt_d = '0;
                    if (pd_dn && !pd_up) q_d[bit_q] = 1'b0;
                    if (bit_q != '0) begin
                        bit_d      = bit_q - BW'(1);
                        q_d[bit_d] = 1'b1;
                    end else begin
                        state_d    = TRACK;
                        cal_d      = 1'b1;
                        blank      = 1'b1;
                        lock_cnt_d = '0;
                        has_last_d = 1'b0;
                    end
                end
            end
            TRACK: begin
                if (step_up) q_d = sat_add(q_q, W'(1));
                if (step_dn) q_d = sat_sub(q_q, W'(1));
                if (step_up || step_dn) begin
                    // A reversal extends the lock run; a repeat breaks it
                    if (has_last_q && (last_up_q != step_up)) begin
                        if (lock_cnt_q != LW'(LOCK_CNT)) lock_cnt_d = lock_cnt_q + LW'(1);
                        if (lock_cnt_q >= LW'(LOCK_CNT - 1)) locked_d = 1'b1;
                    end else if (has_last_q) begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end
                    has_last_d = 1'b1;
                    last_up_d  = step_up;
                end
            end
            RECOVER: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (hld1 || hld2) begin
                    cnt_d = '0;
                end else if (cnt_q == SCW'(SETTLE - 1)) begin
                    state_d = TRACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Jump is applied on entry so RECOVER already presents the new code
        if ((state_q == SAR || state_q == TRACK) && (hld1 || hld2)) begin
            state_d    = RECOVER;
            q_d        = hld1 ? sat_sub(q_q, RECOV_STEP) : sat_add(q_q, RECOV_STEP);
            bit_d      = bit_q;
            cnt_d      = '0;
            lock_cnt_d = '0;
            has_last_d = 1'b0;
            locked_d   = 1'b0;
            cal_d      = cal_q;
            blank      = 1'b0;
        end

        if (!en && state_q != IDLE) begin
            state_d    = IDLE;
            q_d        = q_q;
            bit_d      = bit_q;
            cnt_d      = '0;
            lock_cnt_d = '0;
            has_last_d = 1'b0;
            locked_d   = 1'b0;
            cal_d      = 1'b0;
            blank      = 1'b0;
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= CODE_MID;
            bit_q      <= '0;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            has_last_q <= 1'b0;
            last_up_q  <= 1'b0;
            locked_q   <= 1'b0;
            cal_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            has_last_q <= has_last_d;
            last_up_q  <= last_up_d;
            locked_q   <= locked_d;
            cal_q      <= cal_d;
        end
    end

    assign Q        = q_q;
    assign locked   = locked_q;
    assign cal_done = cal_q;
    assign state    = state_q;

endmodule

// File: doc/dll_code_ctrl.md
Name: dll_code_ctrl

Overview:
- Digital delay-code controller for the FMDLL delay line.
- Consumes sampled phase-detector decisions and the harmonic-lock-detector flags (hld1, hld2; Reset_PD = hld1|hld2).
- Produces the 10-bit delay code Q, which drives the delay line and feeds the harmonic lock detector.
- Sequence: SAR coarse acquisition, then filtered bang-bang tracking, with harmonic recovery on HLD events.

Parameters:
W, 10, delay code width
SETTLE, 3, cycles waited after any code change before PD is sampled
FILT_LEN, 4, vote-filter threshold; net votes needed for a 1-LSB step
LOCK_CNT, 8, consecutive direction-alternating steps needed to assert locked
RECOV_STEP, 64, code jump applied on a harmonic-lock event

Ports:
clk_ext  in  1  single clock; all logic rises on posedge
rst  in  1  synchronous, active-high reset
en  in  1  loop enable
pd_up  in  1  delay too short (synchronised PD output)
pd_dn  in  1  delay too long (synchronised PD output)
hld1  in  1  harmonic flag: delay too long by ≥1 period
hld2  in  1  stuck flag: delay too short / false lock
Q  out  W  delay code, registered
locked  out  1  tracking lock indicator, registered
cal_done  out  1  SAR complete, registered
state  out  3  debug state encoding

Behaviour:
- Interface: one clock, clk_ext; rst is synchronous and active-high.
- Reset (next clk_ext edge with rst=1):
  - Q=10'h200, locked=0, cal_done=0, state=IDLE.
  - Vote, lock and settle counters = 0.
- States: IDLE(0), SAR(1), TRACK(2), RECOVER(3), HOLD(4).
- IDLE:
  - Q holds its value.
  - en=1 → SAR next cycle, with Q=10'h200 and bit index i=9.
- SAR:
  - Each trial waits SETTLE cycles, then samples PD on the next cycle.
  - pd_dn=1 & pd_up=0 → clear bit i. Any other combination → keep bit i.
  - If i>0: set bit i-1 and decrement i. After bit 0: cal_done=1, go to TRACK.
  - Total latency from SAR entry to TRACK: W*(SETTLE+1) cycles (40 with defaults).
- TRACK:
  - Signed vote accumulator v, range ±FILT_LEN.
  - Per cycle: +1 on up-only, −1 on dn-only, 0 on both/neither.
  - Votes are ignored for SETTLE cycles after each code step.
  - v reaches +FILT_LEN → Q+1 (saturates at 1023), v=0.
  - v reaches −FILT_LEN → Q−1 (saturates at 0), v=0.
  - A saturated step still counts as a step for lock purposes.
- Lock:
  - Step opposite to the previous step → lock_cnt+1.
  - Step in the same direction → lock_cnt=0 and locked=0.
  - locked=1 when lock_cnt reaches LOCK_CNT (saturating).
  - locked is cleared on leaving TRACK.
- HLD event: hld1|hld2 sampled high in SAR or TRACK → RECOVER next cycle.
  - RECOVER lasts one cycle.
  - hld1 → Q = max(Q−RECOV_STEP, 0). hld2 only → Q = min(Q+RECOV_STEP, 1023). Both high → hld1 wins.
  - Also in RECOVER: v=0, lock_cnt=0, locked=0.
  - RECOVER → HOLD.
- HOLD:
  - PD ignored.
  - Waits until hld1=hld2=0, then SETTLE more cycles, then → TRACK.
  - Does not re-run SAR, and cal_done stays 1.
  - hld asserted again during the settle period → restart the settle count.
- en=0 in any non-IDLE state:
  - → IDLE next cycle; Q held; locked=0; cal_done=0.
  - Re-enable restarts SAR from 10'h200.
- Priority per cycle: rst > en=0 > HLD event > PD processing.
- rst mid-SAR or mid-HOLD: full reset values on the next edge; no partial state is kept.

Decomposition:
- Shared package dll_pkg:
  - state enum (IDLE..HOLD with the encodings above)
  - W, CODE_MID=10'h200, CODE_MAX=1023
- One sub-module, dll_vote_filter:
  - Signed accumulator with settle blanking and synchronous clear.
  - Outputs step_up/step_dn pulses; the controller owns Q, SAR and lock.

Test Plan:
- Ideal-delay model with target code 10'h2A7; en=1 after reset → Q=10'h2A7 and cal_done=1 exactly 40 cycles after SAR entry.
- TRACK with pd_up held 1 → Q increments by 1 every FILT_LEN+SETTLE cycles; at Q=1023 it stays 1023 with no wrap.
- PD model alternating around the code → locked=1 after 8 alternating steps; then one same-direction pair → locked=0.
- Q=40 in TRACK, pulse hld1 for 1 cycle → Q=0 (saturated) next cycle, then HOLD; TRACK resumes 1+SETTLE cycles after hld1 drops.
- hld1 and hld2 both high with Q=300 → Q=236; hld2 alone with Q=1000 → Q=1023.
- rst=1 for 1 cycle mid-SAR at i=5 → Q=10'h200, state=IDLE, locked=0, cal_done=0; en=0 in TRACK → IDLE with Q held.
